// File: rtl/inst_loader_pkg.sv
// inst_loader_pkg: shared types and constants for the instruction loader.
//   loader_state_t : loader FSM states
//   CHK_INIT       : starting value of the XOR checksum accumulator
//   MAX_LEN_BITS   : width of the big-endian word-count field in a frame
package inst_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StWHi,
        StWLo,
        StChk,
        StDone,
        StErr
    } loader_state_t;

    localparam logic [7:0]  CHK_INIT     = 8'h00;
    localparam int unsigned MAX_LEN_BITS = 16;

endpackage

// File: rtl/inst_loader.sv
// inst_loader: writes a framed byte stream into the instruction memory.
//
// Frame: LEN_HI, LEN_LO (word count N, big-endian), then N x (HI, LO) byte
// pairs forming one W-bit instruction each, then an optional checksum byte.
// Words are written at sequential addresses starting from 0.
//
// Optional feature: define INST_LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte over every byte from LEN_HI through the last LO.
//
// Ports:
//   Clk        in   rising-edge clock
//   Reset_n    in   synchronous active-low reset
//   Start      in   one-cycle pulse; begins or restarts a load
//   ByteIn     in   stream byte
//   ByteValid  in   ByteIn is valid
//   ByteReady  out  a byte is accepted this cycle when ByteValid is high
//   WrEn       out  instruction memory write strobe (one cycle per word)
//   WrAddr     out  write address
//   WrData     out  instruction word
//   Busy       out  load in progress
//   Done       out  sticky: load completed
//   Error      out  sticky: frame rejected
//   WordCount  out  words written in the current load
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int unsigned A = 12,
    parameter int unsigned W = 10
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         Start,
    input  logic [7:0]   ByteIn,
    input  logic         ByteValid,
    output logic         ByteReady,
    output logic         WrEn,
    output logic [A-1:0] WrAddr,
    output logic [W-1:0] WrData,
    output logic         Busy,
    output logic         Done,
    output logic         Error,
    output logic [A:0]   WordCount
);

    // One extra bit so that 2**A itself is representable when comparing lengths.
    localparam int unsigned         LenW     = MAX_LEN_BITS + 1;
    localparam logic [LenW-1:0]     MaxWords = LenW'(1) << A;
    // Bits of a HI byte that may legally be set.
    localparam logic [7:0]          HiMask   = 8'((16'(1) << (W - 8)) - 16'(1));
    localparam logic [A:0]          CntOne   = (A + 1)'(1);

`ifdef INST_LOADER_CHECKSUM_EN
    localparam loader_state_t EndState = StChk;
`else
    localparam loader_state_t EndState = StDone;
`endif

    loader_state_t state_q, state_d;

    logic                    byte_fire;
    logic [7:0]              len_hi_q;
    logic [MAX_LEN_BITS-1:0] len_q;
    logic [W-9:0]            hi_q;
    logic [A:0]              cnt_q;
    logic                    wr_en_q;
    logic [A-1:0]            wr_addr_q;
    logic [W-1:0]            wr_data_q;

    logic len_too_big;
    logic len_zero;
    logic hi_bad;
    logic last_word;

`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0] chk_q;
`endif

    assign byte_fire   = ByteValid && ByteReady;
    assign len_too_big = LenW'({len_hi_q, ByteIn}) > MaxWords;
    assign len_zero    = ({len_hi_q, ByteIn} == 16'h0000);
    assign hi_bad      = |(ByteIn & ~HiMask);
    // True while the LO byte of the final word is on ByteIn.
    assign last_word   = (LenW'(cnt_q) + LenW'(1)) == LenW'(len_q);

    // State register
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; Start overrides everything, including a byte in flight.
    always_comb begin
        state_d = state_q;
        if (Start) begin
            state_d = StLenHi;
        end else if (byte_fire) begin
            case (state_q)
                StLenHi: state_d = StLenLo;
                StLenLo: begin
                    if (len_too_big) begin
                        state_d = StErr;
                    end else if (len_zero) begin
                        state_d = EndState;
                    end else begin
                        state_d = StWHi;
                    end
                end
                StWHi:   state_d = hi_bad ? StErr : StWLo;
                StWLo:   state_d = last_word ? EndState : StWHi;
`ifdef INST_LOADER_CHECKSUM_EN
                StChk:   state_d = (ByteIn == chk_q) ? StDone : StErr;
`endif
                default: state_d = state_q;
            endcase
        end
    end

    // Output decode
    always_comb begin
        ByteReady = 1'b0;
        Busy      = 1'b0;
        Done      = 1'b0;
        Error     = 1'b0;
        case (state_q)
            StLenHi, StLenLo, StWHi, StWLo, StChk: begin
                ByteReady = 1'b1;
                Busy      = 1'b1;
            end
            StDone:  Done  = 1'b1;
            StErr:   Error = 1'b1;
            default: ;
        endcase
    end

    // Datapath: length capture, word assembly, write port and counters
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            len_hi_q  <= 8'h00;
            len_q     <= '0;
            hi_q      <= '0;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= 1'b0;
            if (Start) begin
                cnt_q <= '0;
            end else if (byte_fire) begin
                case (state_q)
                    StLenHi: len_hi_q <= ByteIn;
                    StLenLo: len_q    <= {len_hi_q, ByteIn};
                    StWHi:   hi_q     <= ByteIn[W-9:0];
                    StWLo: begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= cnt_q[A-1:0];
                        wr_data_q <= {hi_q, ByteIn};
                        cnt_q     <= cnt_q + CntOne;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef INST_LOADER_CHECKSUM_EN
    // XOR over every frame byte except the checksum byte itself.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            chk_q <= CHK_INIT;
        end else if (Start) begin
            chk_q <= CHK_INIT;
        end else if (byte_fire && (state_q != StChk)) begin
            chk_q <= chk_q ^ ByteIn;
        end
    end
`endif

    assign WrEn      = wr_en_q;
    assign WrAddr    = wr_addr_q;
    assign WrData    = wr_data_q;
    assign WordCount = cnt_q;

endmodule
